// File: rtl/dest_link_if.sv
// Link-side bundle for dest_link_arbiter: FIFO read ports for D0/D1,
// credit-return pulses, and the outgoing link/status signals.
// master = arbiter side, slave = FIFO/receiver/environment side.
// Optional LINK_PARITY signal is present only when LINK_PARITY_EN is defined.
interface dest_link_if #(
    parameter int DATA_W   = 6,
    parameter int CREDIT_W = 3
);
    logic                init;
    logic                D0_EMPTY;
    logic                D0_VALID;
    logic [DATA_W-1:0]   DATA_OUT_D0;
    logic                D1_EMPTY;
    logic                D1_VALID;
    logic [DATA_W-1:0]   DATA_OUT_D1;
    logic                CREDIT_RET_D0;
    logic                CREDIT_RET_D1;
    logic                POP_D0;
    logic                POP_D1;
    logic [DATA_W-1:0]   LINK_DATA;
    logic                LINK_VALID;
    logic [CREDIT_W-1:0] CREDITS_D0;
    logic [CREDIT_W-1:0] CREDITS_D1;
    logic                LINK_IDLE;
    logic                LINK_ERROR;
`ifdef LINK_PARITY_EN
    logic                LINK_PARITY;
`endif

    modport master (
        input  init, D0_EMPTY, D0_VALID, DATA_OUT_D0, D1_EMPTY, D1_VALID, DATA_OUT_D1,
               CREDIT_RET_D0, CREDIT_RET_D1,
        output POP_D0, POP_D1, LINK_DATA, LINK_VALID, CREDITS_D0, CREDITS_D1, LINK_IDLE,
`ifdef LINK_PARITY_EN
               LINK_PARITY,
`endif
               LINK_ERROR
    );

    modport slave (
        output init, D0_EMPTY, D0_VALID, DATA_OUT_D0, D1_EMPTY, D1_VALID, DATA_OUT_D1,
               CREDIT_RET_D0, CREDIT_RET_D1,
        input  POP_D0, POP_D1, LINK_DATA, LINK_VALID, CREDITS_D0, CREDITS_D1, LINK_IDLE,
`ifdef LINK_PARITY_EN
               LINK_PARITY,
`endif
               LINK_ERROR
    );
endinterface

// File: rtl/dest_link_arbiter.sv
// dest_link_arbiter: drains destination FIFOs D0/D1 onto one link word bus.
// Round-robin between the two destinations, gated by per-destination credits.
// Faults (missing read data, wrong destination bit, credit overflow) park the
// block in a sticky ERROR state until RESET.
// Optional feature macro: LINK_PARITY_EN adds an even-parity bit LINK_PARITY
// registered alongside LINK_DATA.
module dest_link_arbiter #(
    parameter int DATA_W      = 6,
    parameter int CREDIT_W    = 3,
    parameter int MAX_CREDITS = 4,
    parameter int VALID_TMO   = 2
) (
    input  logic        clk,
    input  logic        RESET,
    dest_link_if.master bus
);
    localparam int TMO_W = (VALID_TMO > 2) ? $clog2(VALID_TMO) : 1;
    localparam logic [CREDIT_W-1:0] CRED_MAX  = CREDIT_W'(MAX_CREDITS);
    localparam logic [CREDIT_W-1:0] CRED_ONE  = CREDIT_W'(1);
    localparam logic [TMO_W-1:0]    TMO_LAST  = TMO_W'(VALID_TMO - 1);
    localparam logic [TMO_W-1:0]    TMO_ONE   = TMO_W'(1);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                sel_q, sel_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [CREDIT_W-1:0] cred0_q, cred0_d;
    logic [CREDIT_W-1:0] cred1_q, cred1_d;
    logic [DATA_W-1:0]   link_data_q, link_data_d;
    logic                link_valid_q, link_valid_d;
    logic                link_error_q, link_error_d;
`ifdef LINK_PARITY_EN
    logic                link_parity_q, link_parity_d;
`endif

    logic                elig0_s, elig1_s;
    logic                sel_valid_s, dest_ok_s, send_s;
    logic                send0_s, send1_s;
    logic                ret_ok_s, ret0_s, ret1_s;
    logic                ovf0_s, ovf1_s;
    logic [DATA_W-1:0]   sel_data_s;

    // Next credit value: a send and a return in the same cycle cancel out;
    // an overflowing return leaves the count saturated.
    function automatic logic [CREDIT_W-1:0] credit_next(
        input logic [CREDIT_W-1:0] cur,
        input logic                send,
        input logic                ret,
        input logic                ovf
    );
        logic [CREDIT_W-1:0] nxt;
        if (send && !ret) begin
            nxt = cur - CRED_ONE;
        end else if (ret && !send && !ovf) begin
            nxt = cur + CRED_ONE;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    assign elig0_s     = ~bus.D0_EMPTY & (cred0_q != '0);
    assign elig1_s     = ~bus.D1_EMPTY & (cred1_q != '0);
    assign sel_valid_s = sel_q ? bus.D1_VALID : bus.D0_VALID;
    assign sel_data_s  = sel_q ? bus.DATA_OUT_D1 : bus.DATA_OUT_D0;
    assign dest_ok_s   = (sel_data_s[4] == sel_q);
    assign send_s      = (state_q == ST_WAIT) & sel_valid_s & dest_ok_s;
    assign send0_s     = send_s & ~sel_q;
    assign send1_s     = send_s & sel_q;
    assign ret_ok_s    = (state_q != ST_INIT) & (state_q != ST_ERROR);
    assign ret0_s      = ret_ok_s & bus.CREDIT_RET_D0;
    assign ret1_s      = ret_ok_s & bus.CREDIT_RET_D1;
    assign ovf0_s      = ret0_s & (cred0_q == CRED_MAX) & ~send0_s;
    assign ovf1_s      = ret1_s & (cred1_q == CRED_MAX) & ~send1_s;

    // Next-state, arbitration, credit accounting and link word capture.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        rr_ptr_d     = rr_ptr_q;
        tmo_cnt_d    = tmo_cnt_q;
        link_data_d  = link_data_q;
        link_valid_d = 1'b0;
        cred0_d      = cred0_q;
        cred1_d      = cred1_q;

        case (state_q)
            ST_INIT: begin
                if (bus.init) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (elig0_s || elig1_s) begin
                    sel_d   = (elig0_s && elig1_s) ? rr_ptr_q : elig1_s;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d   = ST_WAIT;
                tmo_cnt_d = '0;
            end
            ST_WAIT: begin
                if (sel_valid_s) begin
                    if (dest_ok_s) begin
                        link_data_d  = sel_data_s;
                        link_valid_d = 1'b1;
                        rr_ptr_d     = ~sel_q;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = ST_ERROR;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_ONE;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_ERROR;
            end
        endcase

        if (state_q == ST_INIT) begin
            cred0_d = bus.init ? CRED_MAX : cred0_q;
            cred1_d = bus.init ? CRED_MAX : cred1_q;
        end else if (ret_ok_s) begin
            cred0_d = credit_next(cred0_q, send0_s, ret0_s, ovf0_s);
            cred1_d = credit_next(cred1_q, send1_s, ret1_s, ovf1_s);
        end else begin
            cred0_d = cred0_q;
            cred1_d = cred1_q;
        end

        // A credit overflow overrides whatever the FSM chose this cycle.
        state_d      = (ovf0_s | ovf1_s) ? ST_ERROR : state_d;
        link_valid_d = link_valid_d & ~(ovf0_s | ovf1_s);
        link_error_d = link_error_q | (state_d == ST_ERROR);
`ifdef LINK_PARITY_EN
        link_parity_d = ^link_data_d;
`endif
    end

    // State and datapath registers; RESET drops any in-flight word.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q       <= ST_INIT;
            sel_q         <= 1'b0;
            rr_ptr_q      <= 1'b0;
            tmo_cnt_q     <= '0;
            cred0_q       <= '0;
            cred1_q       <= '0;
            link_data_q   <= '0;
            link_valid_q  <= 1'b0;
            link_error_q  <= 1'b0;
`ifdef LINK_PARITY_EN
            link_parity_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            rr_ptr_q      <= rr_ptr_d;
            tmo_cnt_q     <= tmo_cnt_d;
            cred0_q       <= cred0_d;
            cred1_q       <= cred1_d;
            link_data_q   <= link_data_d;
            link_valid_q  <= link_valid_d;
            link_error_q  <= link_error_d;
`ifdef LINK_PARITY_EN
            link_parity_q <= link_parity_d;
`endif
        end
    end

    assign bus.POP_D0     = (state_q == ST_ISSUE) & ~sel_q;
    assign bus.POP_D1     = (state_q == ST_ISSUE) & sel_q;
    assign bus.LINK_DATA  = link_data_q;
    assign bus.LINK_VALID = link_valid_q;
    assign bus.CREDITS_D0 = cred0_q;
    assign bus.CREDITS_D1 = cred1_q;
    assign bus.LINK_IDLE  = (state_q == ST_IDLE) & ~(elig0_s | elig1_s);
    assign bus.LINK_ERROR = link_error_q;
`ifdef LINK_PARITY_EN
    assign bus.LINK_PARITY = link_parity_q;
`endif
endmodule

// File: tb/tb_dest_link_arbiter.sv
// Directed self-checking bench for dest_link_arbiter. A small FIFO model
// answers each POP with VALID/data one cycle later; outputs are sampled on
// the falling clock edge.
module tb_dest_link_arbiter;
    logic clk = 1'b0;
    logic RESET = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    dest_link_if #(.DATA_W(6), .CREDIT_W(3)) bus ();

    dest_link_arbiter dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // FIFO model storage: tails written by the stimulus, heads by the responder
    logic [5:0] q0 [0:63];
    logic [5:0] q1 [0:63];
    int q0_head = 0, q0_tail = 0, q1_head = 0, q1_tail = 0;
    bit withhold = 1'b0;

    assign bus.D0_EMPTY = (q0_head == q0_tail);
    assign bus.D1_EMPTY = (q1_head == q1_tail);

    // FIFO read responder: data and VALID one cycle after POP
    always @(posedge clk) begin
        bus.D0_VALID <= 1'b0;
        bus.D1_VALID <= 1'b0;
        if (bus.POP_D0 === 1'b1 && q0_head != q0_tail) begin
            bus.DATA_OUT_D0 <= q0[q0_head];
            bus.D0_VALID    <= !withhold;
            q0_head         <= q0_head + 1;
        end
        if (bus.POP_D1 === 1'b1 && q1_head != q1_tail) begin
            bus.DATA_OUT_D1 <= q1[q1_head];
            bus.D1_VALID    <= !withhold;
            q1_head         <= q1_head + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic push0(input logic [5:0] v);
        q0[q0_tail] = v;
        q0_tail++;
    endtask

    task automatic push1(input logic [5:0] v);
        q1[q1_tail] = v;
        q1_tail++;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic ret(input bit r0, input bit r1);
        bus.CREDIT_RET_D0 = r0;
        bus.CREDIT_RET_D1 = r1;
        cyc();
        bus.CREDIT_RET_D0 = 1'b0;
        bus.CREDIT_RET_D1 = 1'b0;
    endtask

    task automatic wait_pop(input string tag, input bit which);
        int n = 0;
        while (((which ? bus.POP_D1 : bus.POP_D0) !== 1'b1) && n < 20) begin
            cyc();
            n++;
        end
        chk(tag, {31'd0, (which ? bus.POP_D1 : bus.POP_D0)}, 32'd1);
    endtask

    // Wait for the next link word, compare {valid,data}, then step past the pulse
    task automatic get_word(input string tag, input logic [5:0] exp);
        int n = 0;
        while (bus.LINK_VALID !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        chk(tag, {25'd0, bus.LINK_VALID, bus.LINK_DATA}, {25'd0, 1'b1, exp});
        cyc();
    endtask

    task automatic do_reset();
        cyc();
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
    endtask

    initial begin
        bit saw;
        bus.init = 1'b0;
        bus.CREDIT_RET_D0 = 1'b0;
        bus.CREDIT_RET_D1 = 1'b0;

        // Reset state
        cyc(); cyc();
        chk("rst_pop", {30'd0, bus.POP_D1, bus.POP_D0}, 32'd0);
        chk("rst_valid", {31'd0, bus.LINK_VALID}, 32'd0);
        chk("rst_data", {26'd0, bus.LINK_DATA}, 32'd0);
        chk("rst_credits", {26'd0, bus.CREDITS_D1, bus.CREDITS_D0}, 32'd0);
        chk("rst_idle_err", {30'd0, bus.LINK_IDLE, bus.LINK_ERROR}, 32'd0);
`ifdef LINK_PARITY_EN
        chk("rst_parity", {31'd0, bus.LINK_PARITY}, 32'd0);
`endif
        RESET = 1'b0;
        cyc(); cyc();
        chk("init_hold_credits", {26'd0, bus.CREDITS_D1, bus.CREDITS_D0}, 32'd0);

        // 1: single D0 word, POP at t, LINK_VALID at t+2
        push0(6'h05);
        bus.init = 1'b1;
        wait_pop("t1_pop_d0", 1'b0);
        chk("t1_no_pop_d1", {31'd0, bus.POP_D1}, 32'd0);
        cyc();
        chk("t1_t1_novalid", {30'd0, bus.POP_D0, bus.LINK_VALID}, 32'd0);
        cyc();
        chk("t1_t2_word", {25'd0, bus.LINK_VALID, bus.LINK_DATA}, {25'd0, 1'b1, 6'h05});
        chk("t1_credits", {26'd0, bus.CREDITS_D1, bus.CREDITS_D0}, {26'd0, 3'd4, 3'd3});
        chk("t1_idle", {31'd0, bus.LINK_IDLE}, 32'd1);
        cyc();
        chk("t1_pulse_end", {31'd0, bus.LINK_VALID}, 32'd0);

        // 2: both non-empty, D0 served last so D1 goes first, then alternate
        push0(6'h01); push0(6'h02);
        push1(6'h15); push1(6'h16);
        get_word("t2_w0_d1", 6'h15);
        get_word("t2_w1_d0", 6'h01);
        get_word("t2_w2_d1", 6'h16);
        get_word("t2_w3_d0", 6'h02);
        chk("t2_credits", {26'd0, bus.CREDITS_D1, bus.CREDITS_D0}, {26'd0, 3'd2, 3'd1});
        ret(1'b1, 1'b1); ret(1'b1, 1'b1); ret(1'b1, 1'b0);
        cyc();
        chk("t2_refill", {26'd0, bus.CREDITS_D1, bus.CREDITS_D0}, {26'd0, 3'd4, 3'd4});

        // 3: five D0 words with four credits
        for (int i = 1; i <= 5; i++) push0(6'(i));
        for (int i = 1; i <= 4; i++) get_word($sformatf("t3_w%0d", i), 6'(i));
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            saw |= bus.LINK_VALID;
            cyc();
        end
        chk("t3_stall_novalid", {31'd0, saw}, 32'd0);
        chk("t3_idle_nocredit", {28'd0, bus.LINK_IDLE, bus.CREDITS_D0}, {28'd0, 1'b1, 3'd0});
        ret(1'b1, 1'b0);
        get_word("t3_w5_after_ret", 6'h05);
        chk("t3_credit0", {29'd0, bus.CREDITS_D0}, 32'd0);
        ret(1'b1, 1'b0); ret(1'b1, 1'b0); ret(1'b1, 1'b0); ret(1'b1, 1'b0);
        cyc();
        chk("t3_refill", {29'd0, bus.CREDITS_D0}, 32'd4);

        // 4: D1 send with simultaneous credit return, then overflow
        push1(6'h17);
        wait_pop("t4_pop_d1", 1'b1);
        cyc();
        bus.CREDIT_RET_D1 = 1'b1;
        cyc();
        bus.CREDIT_RET_D1 = 1'b0;
        chk("t4_word", {25'd0, bus.LINK_VALID, bus.LINK_DATA}, {25'd0, 1'b1, 6'h17});
        chk("t4_credit_same", {29'd0, bus.CREDITS_D1}, 32'd4);
        chk("t4_no_err_yet", {31'd0, bus.LINK_ERROR}, 32'd0);
        ret(1'b0, 1'b1);
        chk("t4_ovf_err", {31'd0, bus.LINK_ERROR}, 32'd1);
        chk("t4_ovf_sat", {29'd0, bus.CREDITS_D1}, 32'd4);
        chk("t4_err_quiet", {28'd0, bus.POP_D0, bus.POP_D1, bus.LINK_VALID, bus.LINK_IDLE}, 32'd0);

        // 5a: wrong destination bit on D0 data
        do_reset();
        push0(6'h15);
        wait_pop("t5_pop_d0", 1'b0);
        cyc();
        chk("t5_wait_not_idle", {31'd0, bus.LINK_IDLE}, 32'd0);
        cyc();
        chk("t5_dest_err", {30'd0, bus.LINK_ERROR, bus.LINK_VALID}, 32'd2);
        chk("t5_dest_credit", {29'd0, bus.CREDITS_D0}, 32'd4);

        // 5b: read data never arrives
        do_reset();
        withhold = 1'b1;
        push0(6'h03);
        wait_pop("t5b_pop_d0", 1'b0);
        cyc();
        chk("t5b_wait1", {31'd0, bus.LINK_ERROR}, 32'd0);
        cyc();
        chk("t5b_wait2", {31'd0, bus.LINK_ERROR}, 32'd0);
        cyc();
        chk("t5b_tmo_err", {30'd0, bus.LINK_ERROR, bus.LINK_VALID}, 32'd2);
        withhold = 1'b0;

        // 6: RESET while waiting for read data
        do_reset();
        push0(6'h07);
        wait_pop("t6_pop_d0", 1'b0);
        cyc();
        RESET = 1'b1;
        #1;
        chk("t6_rst_outputs", {25'd0, bus.LINK_VALID, bus.POP_D0, bus.POP_D1,
            bus.LINK_IDLE, bus.LINK_ERROR, bus.LINK_DATA == 6'h07, 1'b0}, 32'd0);
        chk("t6_rst_credits", {26'd0, bus.CREDITS_D1, bus.CREDITS_D0}, 32'd0);
        cyc();
        RESET = 1'b0;
        push0(6'h07);
        wait_pop("t6_pop_again", 1'b0);
        cyc(); cyc();
        chk("t6_word", {25'd0, bus.LINK_VALID, bus.LINK_DATA}, {25'd0, 1'b1, 6'h07});
`ifdef LINK_PARITY_EN
        chk("t6_parity", {31'd0, bus.LINK_PARITY}, 32'd1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
